// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter: iterative AES inverse cipher with a reusable key schedule
module inv_cipher_iter #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [127:0]      i_data,
    input  logic [32*NK-1:0]  i_key,
    input  logic              i_key_load,
    output logic              o_valid,
    output logic [127:0]      o_data,
    input  logic              i_ready
);
    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW);
    localparam int RW = $clog2(NR + 1);

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;
    state_t state, state_nx;

    logic [31:0]   w [NW];
    logic [127:0]  st, rk, core;
    logic [IW-1:0] i, im, rb;
    logic [RW-1:0] r;
    logic [7:0]    rcon;
    logic          sched_ok, load, expand_go;
    logic [31:0]   prev, sub_in, sub, tw, w_new;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = b[k] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] q;
        p = a;
        q = 8'h01;
        for (int k = 0; k < 7; k++) begin
            p = gmul(p, p);
            q = gmul(q, p);
        end
        return q;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++)
                o[127-8*(4*c+j) -: 8] = isbox(s[127-8*(4*((c-j+4)%4)+j) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++)
                a[j] = s[127-8*(4*c+j) -: 8];
            for (int j = 0; j < 4; j++)
                o[127-8*(4*c+j) -: 8] = gmul(a[j], 8'h0e) ^ gmul(a[(j+1)%4], 8'h0b)
                                      ^ gmul(a[(j+2)%4], 8'h0d) ^ gmul(a[(j+3)%4], 8'h09);
        end
        return o;
    endfunction

    always_comb begin
        rb     = IW'({r, 2'b00});
        rk     = {w[rb], w[rb + IW'(1)], w[rb + IW'(2)], w[rb + IW'(3)]};
        core   = inv_sr_sb(st) ^ rk;
        im     = i % IW'(NK);
        prev   = w[i - IW'(1)];
        sub_in = (im == '0) ? {prev[23:0], prev[31:24]} : prev;
        sub    = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        tw     = (im == '0) ? sub ^ {rcon, 24'h0} : (NK == 8 && im == IW'(4)) ? sub : prev;
        w_new  = w[i - IW'(NK)] ^ tw;
    end

    always_comb begin
        state_nx  = state;
        load      = state == IDLE && i_valid;
        expand_go = load && (i_key_load || !sched_ok);
        o_ready   = state == IDLE;
        o_valid   = state == DONE;
        case (state)
            IDLE:    state_nx = load ? (expand_go ? EXPAND : ROUND) : IDLE;
            EXPAND:  state_nx = (i == IW'(NW-1)) ? ROUND : EXPAND;
            ROUND:   state_nx = (r == '0) ? DONE : ROUND;
            DONE:    state_nx = i_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            st       <= '0;
            o_data   <= '0;
            sched_ok <= 1'b0;
            r        <= '0;
            i        <= '0;
            rcon     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (load) begin
                    st       <= i_data;
                    i        <= IW'(NK);
                    rcon     <= 8'h01;
                    r        <= RW'(NR);
                    sched_ok <= sched_ok && !i_key_load;
                end
                EXPAND: begin
                    i    <= i + IW'(1);
                    rcon <= (im == '0) ? xt(rcon) : rcon;
                    if (i == IW'(NW-1)) begin
                        sched_ok <= 1'b1;
                        r        <= RW'(NR);
                    end
                end
                ROUND: begin
                    st <= (r == RW'(NR)) ? st ^ rk : inv_mix(core);
                    r  <= r - RW'(1);
                    if (r == '0)
                        o_data <= core;
                end
                default: ;
            endcase
        end
    end

    // the schedule array carries no reset; sched_ok alone decides whether it is trusted
    always_ff @(posedge i_clk) begin
        if (expand_go)
            for (int k = 0; k < NK; k++)
                w[k] <= i_key[32*(NK-1-k) +: 32];
        else if (state == EXPAND)
            w[i] <= w_new;
    end
endmodule

// File: tb/tb_inv_cipher_iter.sv
// tb_inv_cipher_iter: directed FIPS-197 vectors for the NK=4/6/8 iterative inverse cipher
module tb_inv_cipher_iter;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst, kl, rdy;
    logic [2:0]   vld, ordy, ov;
    logic [127:0] din, held;
    logic [255:0] kreg;
    logic [127:0] od [3];
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    inv_cipher_iter #(.NK(4), .NR(10)) u4 (.i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(ordy[0]),
        .i_data(din), .i_key(kreg[255:128]), .i_key_load(kl), .o_valid(ov[0]), .o_data(od[0]), .i_ready(rdy));
    inv_cipher_iter #(.NK(6), .NR(12)) u6 (.i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(ordy[1]),
        .i_data(din), .i_key(kreg[255:64]), .i_key_load(kl), .o_valid(ov[1]), .o_data(od[1]), .i_ready(rdy));
    inv_cipher_iter #(.NK(8), .NR(14)) u8 (.i_clk(clk), .i_rst(rst), .i_valid(vld[2]), .o_ready(ordy[2]),
        .i_data(din), .i_key(kreg), .i_key_load(kl), .o_valid(ov[2]), .o_data(od[2]), .i_ready(rdy));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic run(input int j, input logic [127:0] d, input logic k_ld, input int lat,
                       input logic [127:0] exp, input string tag);
        int n;
        din = d;
        kl = k_ld;
        vld[j] = 1'b1;
        check({tag, " o_ready"}, 128'(ordy[j]), 128'd1);
        @(posedge clk); #1;
        vld[j] = 1'b0;
        n = 0;
        while (!ov[j] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(lat));
        check({tag, " o_data"}, od[j], exp);
    endtask

    task automatic release_out(input int j, input string tag);
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        check({tag, " o_valid fall"}, 128'(ov[j]), 128'd0);
        check({tag, " o_ready rise"}, 128'(ordy[j]), 128'd1);
    endtask

    initial begin
        rst = 1'b1; vld = '0; rdy = 1'b0; kl = 1'b0; din = '0; kreg = KEY;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset o_ready", 128'(ordy[0]), 128'd1);
        check("reset o_valid", 128'(ov[0]), 128'd0);
        check("reset o_data", od[0], 128'd0);

        run(0, CT4, 1'b0, 51, PT, "forced expand");
        release_out(0, "forced expand");
        run(0, CT4, 1'b1, 51, PT, "nk4 expand");
        release_out(0, "nk4 expand");
        kreg = {8{32'hdeadbeef}};
        run(0, CT4, 1'b0, 11, PT, "nk4 reuse");
        kreg = KEY;

        held = od[0];
        for (int c = 0; c < 5; c++) begin
            vld[0] = ~vld[0];
            din = din ^ 128'h0123456789abcdef0123456789abcdef;
            @(posedge clk); #1;
            check("bp o_valid", 128'(ov[0]), 128'd1);
            check("bp o_data", od[0], held);
            check("bp o_ready", 128'(ordy[0]), 128'd0);
        end
        vld[0] = 1'b0;
        release_out(0, "bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp no capture o_valid", 128'(ov[0]), 128'd0);
        check("bp no capture o_ready", 128'(ordy[0]), 128'd1);

        run(1, CT6, 1'b1, 59, PT, "nk6 expand");
        release_out(1, "nk6");
        run(2, CT8, 1'b1, 67, PT, "nk8 expand");
        release_out(2, "nk8");

        din = CT4; kl = 1'b1; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vld[0] = 1'b0;
        check("midrst o_valid", 128'(ov[0]), 128'd0);
        check("midrst o_ready", 128'(ordy[0]), 128'd1);
        check("midrst o_data", od[0], 128'd0);
        run(0, CT4, 1'b0, 51, PT, "after midrst");
        release_out(0, "after midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inv_cipher_iter.md
# inv_cipher_iter

Iterative, clocked AES inverse cipher (FIPS-197), parametrised on key length. It is the sequential successor to the combinational `inv_cipher` and uses the same `i_data`/`i_key`/`o_data` conventions. It expands the key schedule one word per cycle into an internal register file, then runs one decryption round per cycle. The schedule can be retained and reused for subsequent blocks under the same key. It sits behind a valid/ready input port and a valid/ready output port.

## Interface

- NK, 4, key length in 32-bit words; legal values 4, 6, 8.
- NR, 10, round count; must equal NK+6 (10/12/14). Other combinations are unsupported.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  input block and key offered.
- o_ready  out  1  block can accept input; high only in IDLE.
- i_data  in  128  ciphertext; byte 0 is [127:120], column-major.
- i_key  in  32*NK  cipher key; word 0 is the MSBs.
- i_key_load  in  1  sampled at handshake. 1 means expand `i_key`. 0 means reuse the stored schedule.
- o_valid  out  1  plaintext available.
- o_data  out  128  plaintext; same byte order as `i_data`.
- i_ready  in  1  downstream accepts `o_data`.

## Operation

- Word register file w[0 .. 4*(NR+1)-1] holds the schedule. A sched_ok flag is cleared by reset.
- **FSM states:** IDLE, EXPAND, ROUND, DONE.
- **IDLE:**
  - o_ready=1.
  - On i_valid & o_ready: capture i_data into the state register.
  - If i_key_load=1 or sched_ok=0:
    - write w[0..NK-1] from i_key;
    - set i=NK and Rcon=0x01;
    - go to EXPAND.
  - Otherwise go to ROUND with r=NR. The captured i_key is ignored.
- **EXPAND:** one word per cycle, w[i] = w[i-NK] ^ t, where:
  - t = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0} when i mod NK = 0. Rcon then advances by xtime: Rcon·2 in GF(2^8), reduction polynomial 0x11b.
  - t = SubWord(w[i-1]) when NK=8 and i mod NK = 4.
  - t = w[i-1] otherwise.
  - After writing w[4*(NR+1)-1]: set sched_ok=1 and go to ROUND with r=NR.
  - Expansion takes Ne = 4*(NR+1)-NK cycles: 40, 46 or 52.
- **ROUND:** r counts down.
  - r=NR: state ^= roundkey(NR).
  - NR-1 ≥ r ≥ 1: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ roundkey(r)).
  - r=0: o_data = InvSubBytes(InvShiftRows(state)) ^ roundkey(0); go to DONE.
  - roundkey(r) = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- **DONE:**
  - o_valid=1; o_data held stable.
  - i_valid is ignored while not in IDLE.
  - On i_ready, go to IDLE.
- One S-box instance per state byte. Expansion may use four additional S-box instances.

## Timing

- **Reset values:**
  - FSM = IDLE; o_ready=1 from the first cycle after reset.
  - o_valid=0, o_data=0.
  - sched_ok=0; r, i and Rcon cleared.
- **Latency:** from the handshake edge to the first edge with o_valid=1:
  - with expansion: Ne+NR+1 = 51 / 59 / 67 for NK = 4 / 6 / 8;
  - with reuse: NR+1 = 11 / 13 / 15.
- o_valid falls on the edge where i_ready is sampled high in DONE. o_ready rises on that same edge.
- Consequently there is a minimum of one idle cycle between blocks. Throughput with reuse is 1 block per NR+3 cycles when i_ready is held high.
- **Backpressure:** DONE persists indefinitely; o_data must not change while o_valid=1.
- **Reset mid-operation (any state):**
  - return to IDLE, o_valid=0, o_data=0;
  - sched_ok=0, so the next block expands even if i_key_load=0;
  - a partially written schedule is never reused.
- Simultaneous i_valid with i_rst: reset wins and the block is dropped.

## Test plan

- **NK=4, key expansion:** i_key=000102030405060708090a0b0c0d0e0f, i_data=69c4e0d86a7b0430d8cdb78070b4c55a, i_key_load=1 → o_data=00112233445566778899aabbccddeeff, o_valid exactly 51 cycles after the handshake.
- **NK=4, key reuse:** follow-up block with the same ciphertext, i_key_load=0 and i_key set to garbage → same plaintext after 11 cycles.
- **NK=6 and NK=8 instances:**
  - NK=6: key 000102…1617, data dda97ca4864cdfe06eaf70a0ec0d7191 → 00112233…eeff at 59 cycles.
  - NK=8: key 000102…1e1f, data 8ea2b7ca516745bfeafc49904b496089 → 00112233…eeff at 67 cycles.
- **Output backpressure:** hold i_ready=0 for 5 cycles in DONE while toggling i_valid → o_valid stays 1, o_data is constant, o_ready stays 0, no second block is captured.
- **First block after reset with i_key_load=0 (NK=4, first vector)** → expansion is forced; correct plaintext at 51 cycles.
- **Reset mid-operation:** assert i_rst for 1 cycle during EXPAND, then submit the first vector with i_key_load=0 → o_valid=0 and o_ready=1 on the edge after reset; correct result at 51 cycles.
